// File: rtl/rc4_key_dispatch.sv
// Multi-core RC4 key dispatcher: hands ascending keys from [KEY_START, KEY_END] to NUM_CORES
// decrypt cores and reports the first valid key or no_sol. Optional stats via RC4_DISPATCH_STATS_EN.
module rc4_key_dispatch #(
  parameter int KEY_W = 24,
  parameter int NUM_CORES = 4,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_END = {1'b0, {(KEY_W-1){1'b1}}},
  localparam int FC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       enable,
  input  logic [NUM_CORES-1:0]       dc_done,
  input  logic [NUM_CORES-1:0]       dc_invalid,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic [NUM_CORES-1:0]       reset_decrypt,
  output logic [NUM_CORES-1:0]       start_decrypt,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic [FC_W-1:0]            found_core,
  output logic                       no_sol,
  output logic                       busy,
  output logic [31:0]                keys_tried
);

  typedef enum logic [2:0] {
    S_RESET_ALL,
    S_IDLE,
    S_RUN,
    S_DONE,
    S_NO_SOL,
    S_HALT
  } top_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_RESET,
    C_WAIT,
    C_RETIRED
  } core_state_t;

  top_state_t            state_q, state_d;
  core_state_t           core_state_q [NUM_CORES];
  core_state_t           core_state_d [NUM_CORES];
  logic [KEY_W-1:0]      core_key_q [NUM_CORES];
  logic [KEY_W-1:0]      core_key_d [NUM_CORES];
  logic [KEY_W:0]        next_key_q, next_key_d;
  logic                  found_q, found_d;
  logic                  no_sol_q, no_sol_d;
  logic [KEY_W-1:0]      found_key_q, found_key_d;
  logic [FC_W-1:0]       found_core_q, found_core_d;
  logic [NUM_CORES-1:0]  reset_decrypt_q, reset_decrypt_d;
  logic [NUM_CORES-1:0]  start_decrypt_q, start_decrypt_d;
  logic                  busy_q, busy_d;

  logic                  exhausted;
  logic [NUM_CORES-1:0]  wait_vec;
  logic [NUM_CORES-1:0]  done_acc;
  logic [NUM_CORES-1:0]  inv_acc;
  logic                  win_hit;
  logic [KEY_W-1:0]      win_key;
  logic [FC_W-1:0]       win_core;
  logic                  taken;
  logic                  all_retired;

  // The extra counter bit keeps an all-ones KEY_END from wrapping back into range.
  assign exhausted = (next_key_q > {1'b0, KEY_END});

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    assign wait_vec[gi] = (core_state_q[gi] == C_WAIT);
    assign done_acc[gi] = wait_vec[gi] & dc_done[gi];
    assign inv_acc[gi]  = wait_vec[gi] & ~dc_done[gi] & dc_invalid[gi];
    assign core_key[gi*KEY_W +: KEY_W] = core_key_q[gi];
  end

  // Lowest-index accepted done wins; scanning downward leaves the lowest hit last.
  always_comb begin
    win_hit  = 1'b0;
    win_key  = '0;
    win_core = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (done_acc[i]) begin
        win_hit  = 1'b1;
        win_key  = core_key_q[i];
        win_core = FC_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    found_d      = found_q;
    no_sol_d     = no_sol_q;
    found_key_d  = found_key_q;
    found_core_d = found_core_q;
    core_state_d = core_state_q;
    core_key_d   = core_key_q;
    taken        = 1'b0;
    all_retired  = 1'b1;

    if (!enable && (state_q != S_RESET_ALL)) begin
      state_d = S_HALT;
    end else begin
      unique case (state_q)
        S_RESET_ALL: state_d = S_IDLE;
        S_IDLE: begin
          if (start) begin
            state_d    = S_RUN;
            next_key_d = {1'b0, KEY_START};
            for (int i = 0; i < NUM_CORES; i++) begin
              core_state_d[i] = C_IDLE;
            end
          end
        end
        S_RUN: begin
          for (int i = 0; i < NUM_CORES; i++) begin
            unique case (core_state_q[i])
              C_RESET: core_state_d[i] = C_WAIT;
              C_WAIT: begin
                if (!dc_done[i] && dc_invalid[i]) begin
                  core_state_d[i] = C_IDLE;
                end
              end
              C_IDLE: begin
                if (!taken) begin
                  taken = 1'b1;
                  if (!exhausted) begin
                    core_key_d[i]   = next_key_q[KEY_W-1:0];
                    core_state_d[i] = C_RESET;
                    next_key_d      = next_key_q + (KEY_W+1)'(1);
                  end else begin
                    core_state_d[i] = C_RETIRED;
                  end
                end
              end
              default: core_state_d[i] = core_state_q[i];
            endcase
          end
          for (int i = 0; i < NUM_CORES; i++) begin
            if (core_state_d[i] != C_RETIRED) begin
              all_retired = 1'b0;
            end
          end
          if (win_hit) begin
            state_d      = S_DONE;
            found_d      = 1'b1;
            found_key_d  = win_key;
            found_core_d = win_core;
          end else if (all_retired) begin
            state_d  = S_NO_SOL;
            no_sol_d = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Core controls lag the state by one cycle and are silent outside RUN / RESET_ALL.
  always_comb begin
    reset_decrypt_d = '0;
    start_decrypt_d = '0;
    busy_d          = (state_q == S_RUN);
    for (int i = 0; i < NUM_CORES; i++) begin
      reset_decrypt_d[i] = (state_q == S_RESET_ALL) ||
                           ((state_q == S_RUN) && (core_state_q[i] == C_RESET));
      start_decrypt_d[i] = (state_q == S_RUN) && (core_state_q[i] == C_WAIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_RESET_ALL;
      next_key_q      <= {1'b0, KEY_START};
      found_q         <= 1'b0;
      no_sol_q        <= 1'b0;
      found_key_q     <= '0;
      found_core_q    <= '0;
      reset_decrypt_q <= '0;
      start_decrypt_q <= '0;
      busy_q          <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_state_q[i] <= C_IDLE;
        core_key_q[i]   <= '0;
      end
    end else begin
      state_q         <= state_d;
      next_key_q      <= next_key_d;
      found_q         <= found_d;
      no_sol_q        <= no_sol_d;
      found_key_q     <= found_key_d;
      found_core_q    <= found_core_d;
      reset_decrypt_q <= reset_decrypt_d;
      start_decrypt_q <= start_decrypt_d;
      busy_q          <= busy_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_state_q[i] <= core_state_d[i];
        core_key_q[i]   <= core_key_d[i];
      end
    end
  end

`ifdef RC4_DISPATCH_STATS_EN
  logic [31:0] keys_tried_q, keys_tried_d;
  logic [32:0] inv_sum;

  // Counts every accepted invalid in a cycle, saturating at all-ones.
  always_comb begin
    keys_tried_d = keys_tried_q;
    inv_sum      = {1'b0, keys_tried_q};
    if (enable && (state_q == S_IDLE) && start) begin
      keys_tried_d = '0;
    end else if (enable && (state_q == S_RUN)) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        inv_sum = inv_sum + 33'(inv_acc[i]);
      end
      keys_tried_d = inv_sum[32] ? 32'hFFFF_FFFF : inv_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_tried_q <= '0;
    end else begin
      keys_tried_q <= keys_tried_d;
    end
  end

  assign keys_tried = keys_tried_q;
`else
  assign keys_tried = 32'd0;
`endif

  assign reset_decrypt = reset_decrypt_q;
  assign start_decrypt = start_decrypt_q;
  assign busy          = busy_q;
  assign found         = found_q;
  assign found_key     = found_key_q;
  assign found_core    = found_core_q;
  assign no_sol        = no_sol_q;

endmodule

// File: tb/tb_rc4_key_dispatch.sv
// Scoreboard bench for rc4_key_dispatch: several parameter sets, randomized core responders,
// expected dispatch order and results produced from the key range and chosen target key.
module tb_rc4_key_dispatch;
  localparam int NCFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  typedef struct {
    bit fnd;
    bit nos;
    int key;
    int core;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int cfg_kw(input int i);
    case (i)
      0: return 24;
      2: return 4;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_nc(input int i);
    case (i)
      0: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_ks(input int i);
    case (i)
      1: return 3;
      3: return 10;
      default: return 0;
    endcase
  endfunction
  function automatic int cfg_ke(input int i);
    case (i)
      0: return 7;
      1: return 30;
      2: return 15;
      default: return 11;
    endcase
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int KW   = cfg_kw(gi);
    localparam int NC   = cfg_nc(gi);
    localparam int KS_I = cfg_ks(gi);
    localparam int KE_I = cfg_ke(gi);
    localparam int NK   = KE_I - KS_I + 1;
    localparam int FCW  = (NC > 1) ? $clog2(NC) : 1;
    localparam int D2   = (NC >= 3 && NK >= 3) ? 2 : ((NC >= 2 && NK >= 2) ? 1 : 0);
`ifdef RC4_DISPATCH_STATS_EN
    localparam int KT_EXP = NK;
`else
    localparam int KT_EXP = 0;
`endif

    logic           rst, start, en;
    logic [NC-1:0]  resp_done, resp_inv, force_done;
    logic [NC-1:0]  dc_done, dc_invalid;
    logic [NC*KW-1:0] core_key;
    logic [NC-1:0]  reset_decrypt, start_decrypt;
    logic           found, no_sol, busy;
    logic [KW-1:0]  found_key;
    logic [FCW-1:0] found_core;
    logic [31:0]    keys_tried;

    assign dc_done    = resp_done | force_done;
    assign dc_invalid = resp_inv;

    rc4_key_dispatch #(
      .KEY_W    (KW),
      .NUM_CORES(NC),
      .KEY_START(KW'(KS_I)),
      .KEY_END  (KW'(KE_I))
    ) dut (
      .clk          (clk),
      .reset        (rst),
      .start        (start),
      .enable       (en),
      .dc_done      (dc_done),
      .dc_invalid   (dc_invalid),
      .core_key     (core_key),
      .reset_decrypt(reset_decrypt),
      .start_decrypt(start_decrypt),
      .found        (found),
      .found_key    (found_key),
      .found_core   (found_core),
      .no_sol       (no_sol),
      .busy         (busy),
      .keys_tried   (keys_tried)
    );

    int   exp_keys[$];
    res_t exp_res[$];
    bit   tgt_valid, resp_en, res_seen;
    int   tgt, tgt_core, mk;
    res_t rr;
    bit   armed [NC];
    int   dly   [NC];
    int   jkey  [NC];

    // Core model: a job starts on a reset pulse, answers after a random delay once running.
    always @(negedge clk) begin
      for (int c = 0; c < NC; c++) begin
        resp_done[c] = 1'b0;
        resp_inv[c]  = 1'b0;
        if (rst || !resp_en) begin
          armed[c] = 1'b0;
        end else if (busy && reset_decrypt[c]) begin
          armed[c] = 1'b1;
          jkey[c]  = int'(core_key[c*KW +: KW]);
          dly[c]   = int'($urandom_range(0, 3));
        end else if (armed[c] && start_decrypt[c]) begin
          if (dly[c] == 0) begin
            armed[c] = 1'b0;
            if (tgt_valid && jkey[c] == tgt) resp_done[c] = 1'b1;
            else resp_inv[c] = 1'b1;
          end else begin
            dly[c]--;
          end
        end
      end
    end

    // Monitor: every dispatch pops the next expected key; a new result pops the expected outcome.
    always @(negedge clk) begin
      if (!rst) begin
        for (int c = 0; c < NC; c++) begin
          if (busy && reset_decrypt[c]) begin
            mk = int'(core_key[c*KW +: KW]);
            if (exp_keys.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL c%0d_dispatch_extra: core %0d got key %0h, none expected", gi, c, mk);
            end else begin
              chk($sformatf("c%0d_dispatch_key core%0d", gi, c), mk, exp_keys.pop_front());
              if (tgt_valid && mk == tgt) tgt_core = c;
            end
          end
        end
        if (!found && !no_sol) begin
          res_seen = 1'b0;
        end else if (!res_seen) begin
          res_seen = 1'b1;
          if (exp_res.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL c%0d_unexpected_result: found=%0d no_sol=%0d, none expected", gi, found, no_sol);
          end else begin
            rr = exp_res.pop_front();
            chk($sformatf("c%0d_found", gi), found, rr.fnd);
            chk($sformatf("c%0d_no_sol", gi), no_sol, rr.nos);
            if (rr.fnd) begin
              chk($sformatf("c%0d_found_key", gi), found_key, rr.key);
              chk($sformatf("c%0d_found_core", gi), found_core, (rr.core < 0) ? tgt_core : rr.core);
            end else begin
              chk($sformatf("c%0d_keys_left", gi), exp_keys.size(), 0);
            end
            exp_keys.delete();
          end
        end
      end
    end

    task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; en = 1'b1; force_done = '0; resp_en = 1'b0;
      exp_keys.delete();
      exp_res.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    endtask

    task automatic run(input bit tv, input int t, input int ecore, input bit expect_res, input bit resp);
      res_t r;
      tgt_valid = tv; tgt = t; tgt_core = -1;
      for (int k = KS_I; k <= KE_I; k++) exp_keys.push_back(k);
      if (expect_res) begin
        r.fnd = tv; r.nos = !tv; r.key = t; r.core = ecore;
        exp_res.push_back(r);
      end
      resp_en = resp;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_result(input string nm);
      int n = 0;
      while (!(found || no_sol) && n < 3000) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("c%0d_%s_reached", gi, nm), found || no_sol, 1);
      @(posedge clk);
      #1;
      chk($sformatf("c%0d_%s_start_off", gi, nm), start_decrypt, 0);
      chk($sformatf("c%0d_%s_reset_off", gi, nm), reset_decrypt, 0);
      chk($sformatf("c%0d_%s_busy_off", gi, nm), busy, 0);
    endtask

    initial begin
      int n;
      rst = 1'b1; start = 1'b0; en = 1'b1; force_done = '0; resp_en = 1'b0;
      tgt_valid = 1'b0; tgt = 0; tgt_core = -1;
      @(posedge clk);
      #1;
      chk($sformatf("c%0d_rst_found", gi), found, 0);
      chk($sformatf("c%0d_rst_no_sol", gi), no_sol, 0);
      chk($sformatf("c%0d_rst_busy", gi), busy, 0);
      chk($sformatf("c%0d_rst_rdec", gi), reset_decrypt, 0);
      chk($sformatf("c%0d_rst_sdec", gi), start_decrypt, 0);
      chk($sformatf("c%0d_rst_key", gi), core_key, 0);
      chk($sformatf("c%0d_rst_tried", gi), keys_tried, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("c%0d_resetall_rdec", gi), reset_decrypt, {NC{1'b1}});
      @(posedge clk);
      #1;
      chk($sformatf("c%0d_idle_rdec", gi), reset_decrypt, 0);

      // Whole range invalid: every key once, ascending, then no_sol.
      run(1'b0, 0, 0, 1'b1, 1'b1);
      wait_result("exhaust");
      chk($sformatf("c%0d_exhaust_tried", gi), keys_tried, KT_EXP);

      // Second key valid: it lands on core 1 in its first run (core 0 if only one core).
      do_reset();
      run(1'b1, KS_I + ((NK >= 2) ? 1 : 0), (NC >= 2 && NK >= 2) ? 1 : 0, 1'b1, 1'b1);
      wait_result("second");

      for (int r = 0; r < 3; r++) begin
        do_reset();
        run(1'b1, int'($urandom_range(KE_I, KS_I)), -1, 1'b1, 1'b1);
        wait_result("random");
      end

      // Two cores report done together: lowest index must win.
      do_reset();
      run(1'b1, KS_I, 0, 1'b1, 1'b0);
      n = 0;
      while (!(start_decrypt[0] && start_decrypt[D2]) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d_dual_running", gi), start_decrypt[0] && start_decrypt[D2], 1);
      force_done[0]  = 1'b1;
      force_done[D2] = 1'b1;
      @(negedge clk);
      force_done = '0;
      wait_result("dual");

      // Abort via enable: controls drop within two edges, start is then ignored.
      do_reset();
      run(1'b0, 0, 0, 1'b0, 1'b0);
      repeat ($urandom_range(2, 8)) @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk($sformatf("c%0d_halt_rdec", gi), reset_decrypt, 0);
      chk($sformatf("c%0d_halt_sdec", gi), start_decrypt, 0);
      chk($sformatf("c%0d_halt_busy", gi), busy, 0);
      en = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("c%0d_halt_sticky_busy", gi), busy, 0);
      chk($sformatf("c%0d_halt_sticky_sdec", gi), start_decrypt, 0);
      chk($sformatf("c%0d_halt_found", gi), found, 0);
      exp_keys.delete();

      // Reset in the middle of a run, then a fresh search from KEY_START.
      do_reset();
      run(1'b0, 0, 0, 1'b0, 1'b0);
      repeat ($urandom_range(3, 8)) @(negedge clk);
      rst = 1'b1;
      #1;
      chk($sformatf("c%0d_mid_rst_busy", gi), busy, 0);
      chk($sformatf("c%0d_mid_rst_rdec", gi), reset_decrypt, 0);
      chk($sformatf("c%0d_mid_rst_sdec", gi), start_decrypt, 0);
      chk($sformatf("c%0d_mid_rst_key", gi), core_key, 0);
      exp_keys.delete();
      exp_res.delete();
      resp_en = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("c%0d_mid_rst_resetall", gi), reset_decrypt, {NC{1'b1}});
      @(posedge clk);
      #1;
      run(1'b0, 0, 0, 1'b1, 1'b1);
      wait_result("restart");
      chk($sformatf("c%0d_restart_tried", gi), keys_tried, KT_EXP);

      n_done++;
    end
  end

  initial begin
    fork
      wait (n_done == NCFG);
      begin
        #500000;
        n_cmp++;
        n_err++;
        $display("FAIL global_timeout: finished %0d of %0d configurations", n_done, NCFG);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rc4_key_dispatch.md
Name: rc4_key_dispatch

Overview:
- Parametrised multi-core successor of the single-core RC4 key stepper.
- Hands out keys from [KEY_START, KEY_END] to NUM_CORES decrypt cores in parallel; collects per-core done/invalid.
- Reports the first key that decrypts validly, or no_sol once the range is exhausted.
- Sits between top-level control (start/enable) and the decrypt core array.

Parameters:
- KEY_W, 24, key width in bits.
- NUM_CORES, 4, number of decrypt cores driven (>=1).
- KEY_START, 0, first key in the search range (KEY_W bits).
- KEY_END, 24'h7FFFFF, last key inclusive; KEY_START <= KEY_END required.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin search; sampled only in IDLE.
- enable  in  1  low = abort to HALT (sticky until reset).
- dc_done  in  NUM_CORES  core i found valid plaintext.
- dc_invalid  in  NUM_CORES  core i rejected its key.
- core_key  out  NUM_CORES*KEY_W  key for core i, in slice [i*KEY_W +: KEY_W].
- reset_decrypt  out  NUM_CORES  per-core reset pulse.
- start_decrypt  out  NUM_CORES  per-core run level.
- found  out  1  sticky; valid key found.
- found_key  out  KEY_W  winning key.
- found_core  out  max(1,$clog2(NUM_CORES))  winning core index.
- no_sol  out  1  sticky; range exhausted, nothing found.
- busy  out  1  search in progress.
- keys_tried  out  32  count of invalid results (see optional feature).

Behaviour:
- Reset: top FSM -> RESET_ALL; next_key = KEY_START; all outputs 0.
- next_key is a KEY_W+1-bit counter so KEY_END = all-ones never wraps.
- Exhausted = next_key > KEY_END.
- Top FSM:
  - RESET_ALL -> IDLE after 1 cycle; reset_decrypt all high during RESET_ALL.
  - IDLE: start=1 -> RUN.
  - RUN -> DONE on any accepted dc_done.
  - RUN -> NO_SOL when every core is C_RETIRED.
  - DONE, NO_SOL, HALT: terminal until reset.
- enable=0 in any state except RESET_ALL: -> HALT. enable has priority over all other transitions.
- Per-core FSM: C_IDLE, C_RESET, C_WAIT, C_RETIRED.
  - Entering RUN puts all cores in C_IDLE.
  - Assignment in RUN:
    - At most one core per cycle; lowest-index C_IDLE core wins.
    - If not exhausted: core_key[i] <= next_key; next_key++; core -> C_RESET.
    - If exhausted: core -> C_RETIRED.
  - C_RESET: reset_decrypt[i] high; next cycle -> C_WAIT.
  - C_WAIT: start_decrypt[i] high.
    - dc_done[i] -> win.
    - else dc_invalid[i] -> C_IDLE.
    - done and invalid both high: done wins.
  - dc_done/dc_invalid are ignored outside C_WAIT.
- Win:
  - Multiple dc_done in the same cycle: lowest index wins.
  - found=1, found_key=core_key[i], found_core=i; top -> DONE.
  - A done in the same cycle the last core would retire still gives DONE, not NO_SOL.
- Output timing:
  - reset_decrypt, start_decrypt, busy: registered decodes of state, one cycle after the state.
  - In DONE/NO_SOL/HALT, all reset_decrypt/start_decrypt = 0.
  - busy = 1 only in RUN.
- Each key in range is dispatched exactly once, in ascending order.
- Range smaller than NUM_CORES: unused cores retire without ever being started.

Optional Feature:
- Macro RC4_DISPATCH_STATS_EN.
- Defined:
  - keys_tried increments on each accepted dc_invalid (saturates at 2^32-1).
  - Reset to 0 on reset and on IDLE->RUN.
- Undefined: keys_tried tied to 0 and the counter is not built.

Test Plan:
- NUM_CORES=2, range 0..7; core1 asserts dc_done in its first WAIT -> found=1, found_key=1, found_core=1; start_decrypt=00 next cycle.
- NUM_CORES=2, range 0..5; all cores always invalid:
  - core_key values 0..5, each exactly once, ascending.
  - no_sol=1, found=0, keys_tried=6 with macro.
- NUM_CORES=4; cores 0 and 2 assert dc_done in the same cycle -> found_core=0, found_key=core_key[0].
- KEY_W=4, range 0..15, NUM_CORES=1; all invalid -> 16 keys, no wrap to 0, no_sol=1.
- enable dropped during RUN:
  - Within 2 cycles all reset_decrypt/start_decrypt=0, busy=0.
  - start ignored until reset.
- reset asserted mid-RUN:
  - Outputs 0 immediately; reset_decrypt all high one cycle later.
  - Next start dispatches KEY_START first.
